// File: rtl/decade_ctrl_pkg.sv
// Shared types and constants for the decade counter chain controller.
package decade_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

    // Out-of-range preload nibbles collapse to zero
    function automatic logic [3:0] bcd_sanitize(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MIN : d;
    endfunction

endpackage

// File: rtl/decade_chain_ctrl_if.sv
// Command/status bundle between the debounced controls, the counter chain and the display driver.
interface decade_chain_ctrl_if #(
    parameter int unsigned DIGITS = 4
);
    localparam int unsigned W = 4 * DIGITS;

    logic         start;
    logic         stop;
    logic         clear;
    logic         load;
    logic         up_dn;
    logic [W-1:0] load_val;
    logic [W-1:0] bcd;
    logic         tc;
    logic [1:0]   state;
    logic         busy;

    modport master (
        output start, stop, clear, load, up_dn, load_val,
        input  bcd, tc, state, busy
    );

    modport slave (
        input  start, stop, clear, load, up_dn, load_val,
        output bcd, tc, state, busy
    );

endinterface

// File: rtl/decade_digit.sv
// One BCD digit: clear > load > step, wrapping 9->0 up and 0->9 down.
module decade_digit
    import decade_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       up_dn,
    input  logic       ld,
    input  logic [3:0] ld_val,
    input  logic       clr,
    output logic [3:0] q,
    output logic       at_limit
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= BCD_MIN;
        end else if (clr) begin
            q <= BCD_MIN;
        end else if (ld) begin
            q <= bcd_sanitize(ld_val);
        end else if (en) begin
            if (up_dn) begin
                q <= (q == BCD_MAX) ? BCD_MIN : q + 4'd1;
            end else begin
                q <= (q == BCD_MIN) ? BCD_MAX : q - 4'd1;
            end
        end
    end

    // Digit would roll over on its next step in the current direction
    assign at_limit = up_dn ? (q == BCD_MAX) : (q == BCD_MIN);

endmodule

// File: rtl/decade_chain_ctrl.sv
// Run/pause/clear/load controller for a cascaded BCD counter chain with prescaled tick
// and one-cycle terminal-count pulse.
module decade_chain_ctrl
    import decade_ctrl_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned PRESCALE = 10,
    parameter bit          WRAP     = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    decade_chain_ctrl_if.slave bus
);

    localparam int unsigned PW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
    localparam int unsigned W      = 4 * DIGITS;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            tc_q, tc_d;
    logic            busy_q;
    logic            tick;
    logic            step;
    logic            dig_clr;
    logic            dig_ld;
    logic [DIGITS-1:0] lim;
    logic [DIGITS:0]   carry;
    logic [DIGITS-1:0] dig_en;
    logic [W-1:0]      bcd_w;

    // Carry chain: digit k steps only when every lower digit is at its limit
    assign carry[0] = 1'b1;
    assign dig_en   = {DIGITS{step}} & carry[DIGITS-1:0];

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        assign carry[k+1] = carry[k] & lim[k];

        decade_digit u_digit (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (dig_en[k]),
            .up_dn    (bus.up_dn),
            .ld       (dig_ld),
            .ld_val   (bus.load_val[4*k +: 4]),
            .clr      (dig_clr),
            .q        (bcd_w[4*k +: 4]),
            .at_limit (lim[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            tc_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            tc_q    <= tc_d;
            busy_q  <= (state_d == ST_RUN);
        end
    end

    // Command decode (clear > load > stop > start), prescaler and terminal handling
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        tick    = 1'b0;
        dig_clr = 1'b0;
        dig_ld  = 1'b0;
        tc_d    = 1'b0;
        step    = 1'b0;

        if (bus.clear) begin
            state_d = ST_IDLE;
            presc_d = '0;
            dig_clr = 1'b1;
        end else if (bus.load && (state_q != ST_RUN)) begin
            dig_ld = 1'b1;
        end else if (bus.stop && (state_q == ST_RUN)) begin
            // A tick coinciding with stop is dropped; the prescaler parks at its last count
            state_d = ST_PAUSE;
            if (presc_q != P_LAST) begin
                presc_d = presc_q + PW'(1);
            end
        end else if (bus.start && (state_q != ST_RUN)) begin
            state_d = ST_RUN;
            if (state_q != ST_PAUSE) begin
                presc_d = '0;
            end
        end else if (state_q == ST_RUN) begin
            if (presc_q == P_LAST) begin
                presc_d = '0;
                tick    = 1'b1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end

        tc_d = tick & carry[DIGITS];
        step = tick & ~(tc_d & ~WRAP);
        if (tc_d && !WRAP) begin
            state_d = ST_DONE;
        end
    end

    assign bus.bcd   = bcd_w;
    assign bus.state = state_q;
    assign bus.tc    = tc_q;
    assign bus.busy  = busy_q;

endmodule
